// File: rtl/seq_shift_unit.sv
// seq_shift_unit
//   Multi-cycle shift engine: captures an operand, shift amount and mode,
//   then moves the operand one bit position per clock. The finished result
//   is held on out_data, and done pulses for one cycle when it arrives.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   start     request, sampled only while busy=0
//   mode      00 LSL, 01 LSR, 10 ASR, 11 ROL
//   in_data   operand, captured on accept
//   shamt     shift amount 0..DATA_W-1, captured on accept
//   busy      high from accept until completion
//   done      one-cycle completion pulse
//   out_data  last completed result
//
// state  | meaning
// IDLE   | waiting for start; done may be high for the completion cycle
// SHIFT  | one step per edge while count != 0, publish result when count == 0
module seq_shift_unit #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  out_data
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  logic [0:0]         stateReg;
  logic [DATA_W-1:0]  opReg;
  logic [SHAMT_W-1:0] cntReg;
  logic [1:0]         modeReg;
  logic [DATA_W-1:0]  stepVal;

  // One bit position of the selected operation.
  always_comb begin
    stepVal = opReg;
    case (modeReg)
      MODE_LSL: stepVal = {opReg[DATA_W-2:0], 1'b0};
      MODE_LSR: stepVal = {1'b0, opReg[DATA_W-1:1]};
      MODE_ASR: stepVal = {opReg[DATA_W-1], opReg[DATA_W-1:1]};
      MODE_ROL: stepVal = {opReg[DATA_W-2:0], opReg[DATA_W-1]};
      default:  stepVal = opReg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= ST_IDLE;
      opReg    <= '0;
      cntReg   <= '0;
      modeReg  <= MODE_LSL;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_data <= '0;
    end else begin
      // done is a pulse; it is only re-raised on a completion edge.
      done <= 1'b0;
      case (stateReg)
        ST_IDLE: begin
          if (start) begin
            opReg    <= in_data;
            cntReg   <= shamt;
            modeReg  <= mode;
            busy     <= 1'b1;
            stateReg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cntReg != '0) begin
            opReg  <= stepVal;
            cntReg <= cntReg - 1'b1;
          end else begin
            // Count exhausted: the operand register holds the final value.
            out_data <= opReg;
            done     <= 1'b1;
            busy     <= 1'b0;
            stateReg <= ST_IDLE;
          end
        end
        default: begin
          stateReg <= ST_IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit
//   Self-checking bench for seq_shift_unit (DATA_W=16). Expected results come
//   from a whole-word arithmetic reference model; timing expectations come
//   from the shamt+1 latency rule.
module tb_seq_shift_unit;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  logic               clk;
  logic               reset;
  logic               start;
  logic [1:0]         mode;
  logic [DATA_W-1:0]  in_data;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  out_data;

  int errors = 0;
  int checks = 0;

  seq_shift_unit #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .in_data  (in_data),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: shift by n in one go.
  function automatic logic [15:0] refShift(input logic [1:0] m, input logic [15:0] x, input int n);
    logic signed [15:0] sx;
    sx = x;
    case (m)
      2'b00:   return x << n;
      2'b01:   return x >> n;
      2'b10:   return sx >>> n;
      default: return (n == 0) ? x : ((x << n) | (x >> (16 - n)));
    endcase
  endfunction

  // Presents a request before the next edge and returns #1 after the accept edge.
  // Inputs are scrambled afterwards so late changes would corrupt a non-captured value.
  task automatic launch(input logic [1:0] m, input logic [15:0] d, input logic [3:0] s);
    @(negedge clk);
    mode = m; in_data = d; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    mode    = 2'($urandom);
    in_data = 16'($urandom);
    shamt   = 4'($urandom);
  endtask

  // Called #1 after an edge while busy; walks to the completion edge and checks
  // busy/hold every cycle, then the edge count and the result. Returns in the done cycle.
  task automatic waitDone(input string tag, input int expLat, input logic [15:0] expOut,
                          input logic [15:0] prevOut);
    int edges;
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      checks++;
      if (busy !== 1'b1 || out_data !== prevOut) begin
        errors++;
        $display("FAIL %s busy/hold: busy=%b out_data=%h, required busy=1 out_data=%h",
                 tag, busy, out_data, prevOut);
      end
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges !== expLat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, required %0d", tag, edges, expLat);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_data !== expOut) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b out_data=%h, required done=1 busy=0 out_data=%h",
               tag, done, busy, out_data, expOut);
    end
  endtask

  // One cycle after the done cycle: pulse gone, result held.
  task automatic checkAfterDone(input string tag, input logic [15:0] expOut);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_data !== expOut) begin
      errors++;
      $display("FAIL %s post-done: done=%b busy=%b out_data=%h, required done=0 busy=0 out_data=%h",
               tag, done, busy, out_data, expOut);
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] m, input logic [15:0] d,
                       input logic [3:0] s);
    logic [15:0] prev;
    prev = out_data;
    launch(m, d, s);
    waitDone(tag, int'(s) + 1, refShift(m, d, int'(s)), prev);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; in_data = 16'hFFFF; shamt = 4'd3; mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: out_data=%h busy=%b done=%b, required 0000/0/0",
                 i, out_data, busy, done);
      end
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_noaccept: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_legacy_lsl8();
    runOp("lsl8", 2'b00, 16'h00A5, 4'd8);
    checks++;
    if (out_data !== 16'hA500) begin
      errors++;
      $display("FAIL lsl8_const: out_data=%h, required a500", out_data);
    end
    checkAfterDone("lsl8", 16'hA500);
  endtask

  task automatic test_modes();
    logic [15:0] expTab [4];
    expTab[0] = 16'h0010; expTab[1] = 16'h0800; expTab[2] = 16'hF800; expTab[3] = 16'h0018;
    for (int m = 0; m < 4; m++) begin
      runOp("mode", 2'(m), 16'h8001, 4'd4);
      checks++;
      if (out_data !== expTab[m]) begin
        errors++;
        $display("FAIL mode%0d_const: out_data=%h, required %h", m, out_data, expTab[m]);
      end
      checkAfterDone("mode", expTab[m]);
    end
  endtask

  task automatic test_boundaries();
    runOp("shamt0", 2'b00, 16'h1234, 4'd0);
    checkAfterDone("shamt0", 16'h1234);
    runOp("rol15", 2'b11, 16'h8001, 4'd15);
    checks++;
    if (out_data !== 16'hC000) begin
      errors++;
      $display("FAIL rol15_const: out_data=%h, required c000", out_data);
    end
    checkAfterDone("rol15", 16'hC000);
  endtask

  task automatic test_back_to_back();
    logic [15:0] prev;
    prev = out_data;
    launch(2'b00, 16'h0001, 4'd8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b1; in_data = 16'hFFFF; mode = 2'b11; shamt = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("ignore_busy", 5, 16'h0100, prev);
    // Still in the done cycle: this request must be accepted.
    launch(2'b11, 16'h0003, 4'd1);
    waitDone("b2b", 2, 16'h0006, 16'h0100);
    checkAfterDone("b2b", 16'h0006);
  endtask

  task automatic test_reset_abort();
    int doneSeen;
    launch(2'b00, 16'h00FF, 4'd8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_data !== 16'h0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b out_data=%h done=%b, required 0/0000/0", busy, out_data, done);
    end
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles after abort, required 0", doneSeen);
    end
    runOp("after_abort", 2'b00, 16'h0001, 4'd2);
    checks++;
    if (out_data !== 16'h0004) begin
      errors++;
      $display("FAIL after_abort_const: out_data=%h, required 0004", out_data);
    end
    checkAfterDone("after_abort", 16'h0004);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      runOp("random", 2'($urandom), 16'($urandom), 4'($urandom));
      // Half the time chain straight from the done cycle.
      if ($urandom_range(0, 1) == 0) checkAfterDone("random", out_data);
    end
    checkAfterDone("random_end", out_data);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 2'b00; in_data = '0; shamt = '0;
    test_reset();
    test_legacy_lsl8();
    test_modes();
    test_boundaries();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
